// File: rtl/nec_ir_receiver.sv
// NEC infrared frame decoder: leader/space/bit timing, LSB-first shift and checksum check.
// Define IR_REPEAT_EN to report accepted repeat frames via code_valid + ir_repeat.
module nec_ir_receiver #(
    parameter int unsigned TICKS_PER_MS = 50000
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic       ir_in,
    output logic [7:0] IR_button,
    output logic [7:0] ir_addr,
    output logic       code_valid,
    output logic       ir_repeat,
    output logic       frame_error
);

    // state      | meaning
    // IDLE       | waiting for a leader burst, stop bursts absorbed
    // LEAD_BURST | line low, timing the 9 ms leader
    // LEAD_SPACE | line high, 4.5 ms = data frame, 2.25 ms = repeat
    // BIT_BURST  | line low, timing the 562 us bit burst
    // BIT_SPACE  | line high, space length selects bit value
    typedef enum logic [2:0] {
        IDLE,
        LEAD_BURST,
        LEAD_SPACE,
        BIT_BURST,
        BIT_SPACE
    } state_t;

    localparam logic [19:0] LB_MIN  = 20'(8 * TICKS_PER_MS);
    localparam logic [19:0] LB_MAX  = 20'(10 * TICKS_PER_MS);
    localparam logic [19:0] LS_MIN  = 20'(4 * TICKS_PER_MS);
    localparam logic [19:0] LS_MAX  = 20'(5 * TICKS_PER_MS);
    localparam logic [19:0] RS_MIN  = 20'(2 * TICKS_PER_MS);
    localparam logic [19:0] RS_MAX  = 20'(5 * TICKS_PER_MS / 2);
    localparam logic [19:0] BIT_MIN = 20'(2 * TICKS_PER_MS / 5);
    localparam logic [19:0] BIT_MAX = 20'(3 * TICKS_PER_MS / 4);
    localparam logic [19:0] ONE_MIN = 20'(7 * TICKS_PER_MS / 5);
    localparam logic [19:0] ONE_MAX = 20'(2 * TICKS_PER_MS);
    localparam logic [19:0] TIMEOUT = 20'(12 * TICKS_PER_MS);

    function automatic logic in_range(input logic [19:0] v, input logic [19:0] lo,
                                      input logic [19:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    state_t      state;
    logic        sync1, sync2, prev;
    logic        fall, rise;
    logic [19:0] dur_cnt;
    logic [4:0]  bit_cnt;
    logic [30:0] shift_reg;
    logic [31:0] next_word;
    logic        space_one, space_zero;

`ifdef IR_REPEAT_EN
    logic have_code;
    logic repeat_q;
    assign ir_repeat = repeat_q;
`else
    assign ir_repeat = 1'b0;
`endif

    assign fall = prev & ~sync2;
    assign rise = ~prev & sync2;

    assign space_one  = in_range(dur_cnt, ONE_MIN, ONE_MAX);
    assign space_zero = in_range(dur_cnt, BIT_MIN, BIT_MAX);
    // Only 31 bits are stored: the 32nd bit completes the word combinationally.
    assign next_word  = {space_one, shift_reg};

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= ir_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            dur_cnt <= '0;
        end else if (fall || rise) begin
            dur_cnt <= '0;
        end else if (dur_cnt != TIMEOUT) begin
            dur_cnt <= dur_cnt + 20'd1;
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            IR_button   <= 8'h00;
            ir_addr     <= 8'h00;
            code_valid  <= 1'b0;
            frame_error <= 1'b0;
`ifdef IR_REPEAT_EN
            have_code   <= 1'b0;
            repeat_q    <= 1'b0;
`endif
        end else begin
            code_valid  <= 1'b0;
            frame_error <= 1'b0;
`ifdef IR_REPEAT_EN
            repeat_q    <= 1'b0;
`endif
            // An edge arriving with the saturated count still gets decoded normally.
            if (state != IDLE && !fall && !rise && dur_cnt == TIMEOUT) begin
                frame_error <= 1'b1;
                state       <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (fall) state <= LEAD_BURST;
                    end
                    LEAD_BURST: begin
                        if (rise) begin
                            if (in_range(dur_cnt, LB_MIN, LB_MAX)) begin
                                state <= LEAD_SPACE;
                            end else begin
                                frame_error <= 1'b1;
                                state       <= IDLE;
                            end
                        end
                    end
                    LEAD_SPACE: begin
                        if (fall) begin
                            if (in_range(dur_cnt, LS_MIN, LS_MAX)) begin
                                bit_cnt <= '0;
                                state   <= BIT_BURST;
                            end else if (in_range(dur_cnt, RS_MIN, RS_MAX)) begin
`ifdef IR_REPEAT_EN
                                if (have_code) begin
                                    code_valid <= 1'b1;
                                    repeat_q   <= 1'b1;
                                end
`endif
                                state <= IDLE;
                            end else begin
                                frame_error <= 1'b1;
                                state       <= IDLE;
                            end
                        end
                    end
                    BIT_BURST: begin
                        if (rise) begin
                            if (in_range(dur_cnt, BIT_MIN, BIT_MAX)) begin
                                state <= BIT_SPACE;
                            end else begin
                                frame_error <= 1'b1;
                                state       <= IDLE;
                            end
                        end
                    end
                    BIT_SPACE: begin
                        if (fall) begin
                            if (space_one || space_zero) begin
                                shift_reg <= next_word[31:1];
                                if (bit_cnt == 5'd31) begin
                                    state <= IDLE;
                                    if (next_word[15:8] == ~next_word[7:0] &&
                                        next_word[31:24] == ~next_word[23:16]) begin
                                        ir_addr    <= next_word[7:0];
                                        IR_button  <= next_word[23:16];
                                        code_valid <= 1'b1;
`ifdef IR_REPEAT_EN
                                        have_code  <= 1'b1;
`endif
                                    end else begin
                                        frame_error <= 1'b1;
                                    end
                                end else begin
                                    bit_cnt <= bit_cnt + 5'd1;
                                    state   <= BIT_BURST;
                                end
                            end else begin
                                frame_error <= 1'b1;
                                state       <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nec_ir_receiver.sv
// Directed + randomized bench for nec_ir_receiver with a time-scaled clock (40 ticks per ms).
// Expectations come from a frame-level model of the NEC rules; honours IR_REPEAT_EN.
module tb_nec_ir_receiver;

    localparam int T = 40;
`ifdef IR_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk_50 = 1'b0;
    logic       reset_n = 1'b0;
    logic       ir_in = 1'b1;
    logic [7:0] IR_button, ir_addr;
    logic       code_valid, ir_repeat, frame_error;

    int cyc = 0;
    int n_valid = 0, n_rep = 0, n_err = 0, n_both = 0;
    int last_pulse_cyc = -1;
    int last_fall_cyc = 0;
    int n_checks = 0, n_fail = 0;

    logic [7:0] m_button = 8'h00, m_addr = 8'h00;
    bit         m_have = 1'b0;
    int         bv, br, be;

    nec_ir_receiver #(.TICKS_PER_MS(T)) dut (
        .clk_50      (clk_50),
        .reset_n     (reset_n),
        .ir_in       (ir_in),
        .IR_button   (IR_button),
        .ir_addr     (ir_addr),
        .code_valid  (code_valid),
        .ir_repeat   (ir_repeat),
        .frame_error (frame_error)
    );

    always #10 clk_50 = ~clk_50;

    always @(posedge clk_50) cyc <= cyc + 1;

    always @(negedge clk_50) begin
        if (code_valid) begin
            n_valid++;
            last_pulse_cyc = cyc;
        end
        if (ir_repeat) n_rep++;
        if (frame_error) begin
            n_err++;
            last_pulse_cyc = cyc;
        end
        if (code_valid && frame_error) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rnd(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    function automatic logic [31:0] mk(input logic [7:0] addr, input logic [7:0] cmd);
        return {~cmd, cmd, ~addr, addr};
    endfunction

    task automatic drive(input logic lvl, input int n);
        ir_in = lvl;
        if (!lvl) last_fall_cyc = cyc;
        repeat (n) @(negedge clk_50);
    endtask

    task automatic send_bits(input logic [31:0] w, input int nbits);
        drive(1'b0, rnd(9 * T - 20, 9 * T + 20));
        drive(1'b1, rnd(9 * T / 2 - 10, 9 * T / 2 + 10));
        for (int i = 0; i < nbits; i++) begin
            drive(1'b0, rnd(19, 27));
            drive(1'b1, w[i] ? rnd(60, 76) : rnd(19, 27));
        end
    endtask

    task automatic snap();
        bv = n_valid;
        br = n_rep;
        be = n_err;
    endtask

    task automatic expect_txn(input string tag, input int ev, input int er, input int ee);
        check({tag, "_valid_cnt"}, n_valid - bv, ev);
        check({tag, "_repeat_cnt"}, n_rep - br, er);
        check({tag, "_error_cnt"}, n_err - be, ee);
        check({tag, "_button"}, {24'h0, IR_button}, {24'h0, m_button});
        check({tag, "_addr"}, {24'h0, ir_addr}, {24'h0, m_addr});
    endtask

    task automatic run_frame(input string tag, input logic [31:0] w);
        int ev, ee;
        snap();
        if (w[15:8] == ~w[7:0] && w[31:24] == ~w[23:16]) begin
            m_addr   = w[7:0];
            m_button = w[23:16];
            m_have   = 1'b1;
            ev = 1;
            ee = 0;
        end else begin
            ev = 0;
            ee = 1;
        end
        send_bits(w, 32);
        drive(1'b0, rnd(19, 27));
        drive(1'b1, 60);
        expect_txn(tag, ev, 0, ee);
        check({tag, "_latency"}, last_pulse_cyc - last_fall_cyc, 3);
    endtask

    task automatic run_repeat(input string tag);
        int ev;
        snap();
        ev = (REP_EN && m_have) ? 1 : 0;
        drive(1'b0, rnd(9 * T - 20, 9 * T + 20));
        drive(1'b1, rnd(9 * T / 4 - 5, 9 * T / 4 + 5));
        drive(1'b0, rnd(19, 27));
        drive(1'b1, 60);
        expect_txn(tag, ev, ev, 0);
        if (ev != 0) check({tag, "_latency"}, last_pulse_cyc - last_fall_cyc, 3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_button"}, {24'h0, IR_button}, 32'h0);
        check({tag, "_addr"}, {24'h0, ir_addr}, 32'h0);
        check({tag, "_pulses"}, {29'h0, code_valid, ir_repeat, frame_error}, 32'h0);
    endtask

    initial begin
        logic [31:0] w;
        int          r, lat;

        repeat (5) @(negedge clk_50);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (10) @(negedge clk_50);
        check("post_reset_quiet", n_valid + n_err + n_rep, 0);

        run_repeat("rep_no_code");
        run_frame("f_00_0f", mk(8'h00, 8'h0F));
        run_frame("f_13_bad", {8'hED, 8'h13, 8'hFF, 8'h00});
        run_frame("f_00_10", mk(8'h00, 8'h10));
        run_repeat("rep_after_10");

        snap();
        drive(1'b0, 7 * T);
        drive(1'b1, 200);
        expect_txn("lead_7ms", 0, 0, 1);
        run_frame("f_after_short", mk(8'h00, 8'h0F));

        snap();
        send_bits(mk(8'h5A, 8'h77), 10);
        drive(1'b0, 15 * T);
        lat = last_pulse_cyc - last_fall_cyc;
        drive(1'b1, 100);
        expect_txn("timeout", 0, 0, 1);
        check("timeout_at_12ms", (lat >= 12 * T && lat <= 12 * T + 6) ? 1 : 0, 1);
        run_frame("f_after_timeout", mk(8'hA5, 8'h3C));

        send_bits(mk(8'h00, 8'h13), 16);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        m_button = 8'h00;
        m_addr   = 8'h00;
        m_have   = 1'b0;
        repeat (5) @(negedge clk_50);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_50);
        run_frame("f_00_13", mk(8'h00, 8'h13));

        for (int k = 0; k < 8; k++) begin
            r = rnd(0, 9);
            if (r < 2) begin
                run_repeat("rnd_repeat");
            end else begin
                w = mk(8'($urandom), 8'($urandom));
                if (r < 5) w = w ^ (32'h1 << (rnd(0, 1) == 1 ? rnd(24, 31) : rnd(8, 15)));
                run_frame("rnd_frame", w);
            end
        end

        check("never_both", n_both, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nec_ir_receiver.md
NEC_IR_RECEIVER -- requirements
Module: nec_ir_receiver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; no other clock or reset inputs.
REQ-002 clk_50  input  1  50 MHz system clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 ir_in  input  1  raw demodulated IR receiver output, asynchronous to clk_50; idle high, carrier burst = low.
REQ-005 IR_button  output  8  last accepted NEC command byte, held until the next accepted frame.
REQ-006 ir_addr  output  8  last accepted NEC address byte, held.
REQ-007 code_valid  output  1  one-cycle pulse when IR_button/ir_addr are updated or a repeat is accepted.
REQ-008 ir_repeat  output  1  one-cycle pulse, coincident with code_valid, for an accepted repeat frame.
REQ-009 frame_error  output  1  one-cycle pulse on any timing, timeout or checksum failure.

Function
REQ-010 ir_in SHALL pass through a 2-flop synchronizer plus a previous-value flop; fall = prev high and sync low, rise = prev low and sync high.
REQ-011 A 20-bit duration counter SHALL clear on every fall/rise, otherwise increment, saturating at 600000.
REQ-012 States SHALL be IDLE, LEAD_BURST, LEAD_SPACE, BIT_BURST, BIT_SPACE; IDLE ignores rise and enters LEAD_BURST on fall.
REQ-013 LEAD_BURST on rise: count 400000..500000 (8-10 ms) -> LEAD_SPACE; otherwise frame_error, -> IDLE.
REQ-014 LEAD_SPACE on fall: 200000..250000 -> BIT_BURST with bit count 0; 100000..125000 -> repeat handling (REQ-020), -> IDLE; otherwise frame_error, -> IDLE.
REQ-015 BIT_BURST on rise: 20000..37500 -> BIT_SPACE; otherwise frame_error, -> IDLE.
REQ-016 BIT_SPACE on fall: 20000..37500 = bit 0, 70000..100000 = bit 1, shifted LSB-first into a 32-bit register (new bit to bit 31); any other count -> frame_error, -> IDLE.
REQ-017 After the 32nd bit, -> IDLE; if byte1 = ~byte0 and byte3 = ~byte2, load ir_addr = byte0, IR_button = byte2, pulse code_valid; otherwise pulse frame_error only, outputs unchanged.
REQ-018 In any non-IDLE state, a count reaching 600000 (12 ms) SHALL pulse frame_error and return to IDLE; an edge in the same cycle takes precedence over timeout.
REQ-019 code_valid/frame_error SHALL be registered, asserted exactly 3 clk_50 rising edges after the terminating ir_in fall; never both in one cycle.
REQ-020 Accepted repeat: only if a valid frame was accepted since reset (have_code flag); else silently -> IDLE, no error.
REQ-021 The stop burst after frame/repeat SHALL be absorbed in IDLE (rise ignored), not flagged.

Reset
REQ-022 reset_n low SHALL immediately force IDLE, counters 0, shift register 0, have_code 0, IR_button 8'h00, ir_addr 8'h00, all pulses 0.
REQ-023 Synchronizer and previous-value flops SHALL reset to 1 so release creates no spurious fall.
REQ-024 Reset mid-frame SHALL discard the partial frame; decoding resumes with the next leader.

Configuration
REQ-025 Macro IR_REPEAT_EN: defined -> accepted repeat pulses code_valid and ir_repeat together, IR_button/ir_addr unchanged.
REQ-026 IR_REPEAT_EN undefined -> repeat frames return to IDLE with no pulse of any output; ir_repeat tied 0; have_code logic removed.

Verification
REQ-027 Frame addr 8'h00 cmd 8'h0F -> IR_button=8'h0F, ir_addr=8'h00, single code_valid pulse, frame_error never high.
REQ-028 Frame cmd 8'h13 with inverse byte 8'hED -> single frame_error pulse, IR_button stays 8'h0F, no code_valid.
REQ-029 Valid cmd 8'h10 then repeat (9 ms + 2.25 ms + stop) -> macro on: code_valid+ir_repeat pulse, IR_button=8'h10; macro off: no pulses.
REQ-030 Leader burst 7 ms -> frame_error, no decode; following valid 8'h0F frame decodes normally.
REQ-031 ir_in held low 15 ms at bit 10 -> frame_error at 12 ms, IDLE; next valid frame decodes.
REQ-032 reset_n low at bit 16 of an 8'h13 frame -> all outputs 0 immediately; subsequent full 8'h13 frame -> IR_button=8'h13.
